vt_text_scan: RTL and testbench

Text-mode scanout engine: the display-side reader of the character RAM that the terminal core writes. For each scanline requested by the video timing generator it reads the 100 character codes of the matching text row, looks each up in the font ROM, and streams 100 glyph bytes, with cursor overlay, to the pixel serializer. It honours the terminal's scroll position (`top_row`) so that the 32-row circular character store is shown as 30 visible rows.

---
 rtl/vt_text_scan.sv | 160 ++++++++++++++++
 tb/tb_vt_text_scan.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vt_text_scan.sv
// Text-mode scanout: reads one 100-column character row per scanline, looks each code up
// in the font ROM and streams glyph bytes (with cursor inversion) through a small FWFT FIFO.
module vt_text_scan #(
    parameter int OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_low,
    input  logic [4:0]  top_row,
    input  logic [4:0]  cursor_row,
    input  logic [6:0]  cursor_col,
    input  logic        cursor_on,
    input  logic        line_valid,
    output logic        line_ready,
    input  logic [8:0]  line_y,
    output logic        ram_rd_en,
    output logic [4:0]  ram_row,
    output logic [6:0]  ram_col,
    input  logic [7:0]  ram_data,
    output logic        font_rd_en,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_bits,
    output logic        out_last
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state;
    logic [6:0]  col;
    logic [4:0]  sr_q, top_q, crow_q;
    logic [3:0]  gl_q;
    logic [6:0]  ccol_q;
    logic        con_q;

    logic [4:0]  pr;
    logic        blank, issue;
    logic [1:0]  inflight;

    logic        s1_valid, s1_cur, s1_last, s1_blank;
    logic        s2_valid, s2_cur, s2_last, s2_blank;

    logic [7:0]  mem_bits [OUT_DEPTH];
    logic        mem_last [OUT_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic        push, pop;
    logic [7:0]  wdata;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pr       = top_q + sr_q;
    assign blank    = (sr_q >= 5'd30);
    assign inflight = {1'b0, s1_valid} + {1'b0, s2_valid};
    assign issue    = (state == FETCH) && ((32'(count) + 32'(inflight)) < 32'(OUT_DEPTH));

    assign line_ready = (state == IDLE);
    assign ram_rd_en  = issue && !blank;
    assign ram_row    = ram_rd_en ? pr  : '0;
    assign ram_col    = ram_rd_en ? col : '0;
    assign font_rd_en = s1_valid && !s1_blank;
    assign font_addr  = font_rd_en ? {ram_data, gl_q} : '0;

    assign push  = s2_valid;
    assign wdata = s2_blank ? '0 : (font_data ^ {8{s2_cur}});
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_bits  = out_valid ? mem_bits[rd_ptr] : '0;
    assign out_last  = out_valid ? mem_last[rd_ptr] : 1'b0;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state    <= IDLE;
            col      <= '0;
            sr_q     <= '0;
            gl_q     <= '0;
            top_q    <= '0;
            crow_q   <= '0;
            ccol_q   <= '0;
            con_q    <= 1'b0;
            s1_valid <= 1'b0;
            s1_cur   <= 1'b0;
            s1_last  <= 1'b0;
            s1_blank <= 1'b0;
            s2_valid <= 1'b0;
            s2_cur   <= 1'b0;
            s2_last  <= 1'b0;
            s2_blank <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_cur   <= con_q && (pr == crow_q) && (col == ccol_q);
            s1_last  <= (col == 7'd99);
            s1_blank <= blank;
            s2_valid <= s1_valid;
            s2_cur   <= s1_cur;
            s2_last  <= s1_last;
            s2_blank <= s1_blank;
            case (state)
                IDLE: begin
                    if (line_valid) begin
                        sr_q   <= line_y[8:4];
                        gl_q   <= line_y[3:0];
                        top_q  <= top_row;
                        crow_q <= cursor_row;
                        ccol_q <= cursor_col;
                        con_q  <= cursor_on;
                        col    <= '0;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (col == 7'd99) begin
                            col   <= '0;
                            state <= DRAIN;
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 2 lands in the FIFO this cycle, so nothing remains in flight after it.
                    if (!s1_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: out_bits/out_last are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_bits[wr_ptr] <= wdata;
            mem_last[wr_ptr] <= s2_last;
        end
    end

endmodule

// File: tb/tb_vt_text_scan.sv
// Bench for vt_text_scan: RAM/ROM models, a line-level reference model and per-line checks
// driven from a vector table, hand-written corner sequences and randomized lines.
module tb_vt_text_scan;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_low = 1'b1;
    logic [4:0]  top_row = '0;
    logic [4:0]  cursor_row = '0;
    logic [6:0]  cursor_col = '0;
    logic        cursor_on = 1'b0;
    logic        line_valid = 1'b0;
    logic        line_ready;
    logic [8:0]  line_y = '0;
    logic        ram_rd_en;
    logic [4:0]  ram_row;
    logic [6:0]  ram_col;
    logic [7:0]  ram_data = '0;
    logic        font_rd_en;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_bits;
    logic        out_last;

    vt_text_scan #(.OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_low(reset_low),
        .top_row(top_row), .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_on(cursor_on),
        .line_valid(line_valid), .line_ready(line_ready), .line_y(line_y),
        .ram_rd_en(ram_rd_en), .ram_row(ram_row), .ram_col(ram_col), .ram_data(ram_data),
        .font_rd_en(font_rd_en), .font_addr(font_addr), .font_data(font_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_last(out_last)
    );

    always #5 clk = ~clk;

    logic [7:0] ram  [32][100];
    logic [7:0] font [4096];

    always @(posedge clk) begin
        if (ram_rd_en)  ram_data  <= (ram_col < 7'd100) ? ram[ram_row][ram_col] : 8'h00;
        if (font_rd_en) font_data <= font[font_addr];
    end

    typedef struct {
        logic [7:0] bits;
        logic       last;
        logic       blank;
    } exp_t;

    typedef struct {
        int         y, top, crow, ccol, con, pct;
        int         exp_row;   // -1: blank line, no RAM reads
        int         faddr;     // -1: font address not checked
        int         inv_col;   // -1: no hand-derived byte check
        logic [7:0] inv_val;
    } vec_t;

    exp_t expq[$];
    exp_t e;
    int checks = 0, errors = 0;
    int ready_pct = 100;

    int ncyc = 0, rd_cnt, rd_bad, font_cnt, font_bad, lasts, credit_bad;
    int exp_row, exp_col, exp_faddr, first_valid, ready_rise, last_rd_cyc, acc;
    int total_issued = 0, nb_popped = 0, byte_idx = 0;
    bit chk_faddr;
    logic prev_ready = 1'b1;
    logic [7:0] got [100];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: whole line from the scroll/cursor/blank rules applied to the RAM and font arrays.
    function automatic void push_line(input int y, input int top, input int crow, input int ccol, input int con);
        int sr, pr;
        logic [3:0] gl;
        logic [11:0] a;
        exp_t x;
        sr = y / 16;
        gl = 4'(y % 16);
        pr = (top + sr) % 32;
        for (int c = 0; c < 100; c++) begin
            a = {ram[pr][c], gl};
            x.blank = (sr >= 30);
            x.last  = (c == 99);
            if (sr >= 30) x.bits = 8'h00;
            else if (con != 0 && pr == crow && c == ccol) x.bits = ~font[a];
            else x.bits = font[a];
            expq.push_back(x);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_low) begin
            ncyc++;
            if (ram_rd_en) begin
                rd_cnt++;
                total_issued++;
                if (int'(ram_row) != exp_row || int'(ram_col) != exp_col) rd_bad++;
                exp_col = (exp_col == 99) ? 0 : exp_col + 1;
                last_rd_cyc = ncyc;
            end
            if (font_rd_en) begin
                font_cnt++;
                if (chk_faddr && int'(font_addr) != exp_faddr) font_bad++;
            end
            if (out_valid && first_valid < 0) first_valid = ncyc;
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL stream extra byte: got %02h with nothing expected", out_bits);
                end else begin
                    e = expq.pop_front();
                    if (out_bits !== e.bits || out_last !== e.last) begin
                        errors++;
                        $display("FAIL stream byte %0d: got %02h last %0b, expected %02h last %0b",
                                 byte_idx, out_bits, out_last, e.bits, e.last);
                    end
                    if (!e.blank) nb_popped++;
                    got[byte_idx] = out_bits;
                    byte_idx = e.last ? 0 : ((byte_idx + 1) % 100);
                    if (e.last) lasts++;
                end
            end
            if (total_issued - nb_popped > DEPTH) credit_bad++;
            if (line_ready && !prev_ready) ready_rise = ncyc;
            prev_ready = line_ready;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (int'($urandom_range(99)) < ready_pct);
    end

    task automatic start_line(input vec_t v, input bit hold);
        bit ok;
        exp_row = v.exp_row; exp_col = 0;
        chk_faddr = (v.faddr >= 0); exp_faddr = v.faddr;
        rd_cnt = 0; rd_bad = 0; font_cnt = 0; font_bad = 0; lasts = 0; credit_bad = 0;
        first_valid = -1;
        ready_pct = v.pct;
        @(posedge clk); #1;
        line_y = 9'(v.y); top_row = 5'(v.top); cursor_row = 5'(v.crow);
        cursor_col = 7'(v.ccol); cursor_on = (v.con != 0);
        line_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (line_ready) begin ok = 1'b1; break; end
        end
        chk("accept", int'(ok), 1);
        acc = ncyc;
        ready_rise = -1;
        push_line(v.y, v.top, v.crow, v.ccol, v.con);
        @(posedge clk); #1;
        if (!hold) begin
            line_valid = 1'b0;
            line_y = 9'($urandom); top_row = 5'($urandom); cursor_row = 5'($urandom);
            cursor_col = 7'($urandom); cursor_on = 1'($urandom);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk); #1;
            if (expq.size() == 0 && line_ready) begin done = 1'b1; break; end
        end
        chk(name, int'(done), 1);
    endtask

    task automatic run_vec(input vec_t v);
        bit blank;
        blank = (v.exp_row < 0);
        start_line(v, 1'b0);
        wait_drain("line_done");
        chk("rd_count", rd_cnt, blank ? 0 : 100);
        chk("rd_addr_bad", rd_bad, 0);
        chk("font_count", font_cnt, blank ? 0 : 100);
        chk("last_count", lasts, 1);
        chk("credit_bad", credit_bad, 0);
        if (chk_faddr) chk("font_addr_bad", font_bad, 0);
        if (v.inv_col >= 0) chk("cursor_byte", int'(got[v.inv_col]), int'(v.inv_val));
        if (v.pct == 100) chk("first_valid_latency", first_valid - acc, 4);
        if (v.pct == 100 && !blank) chk("ready_after_col99", ready_rise - last_rd_cyc, 3);
    endtask

    vec_t tbl [9];
    vec_t v;
    int   accs [3];

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 100; c++)
                ram[r][c] = (r == 0) ? 8'h41 : 8'($urandom);
        for (int a = 0; a < 4096; a++) font[a] = 8'($urandom);
        ram[3][99] = 8'h7E; font[12'h7E0] = 8'h18;
        ram[2][0]  = 8'h33; font[12'h334] = 8'hA5;

        tbl[0] = '{y:5,   top:0,  crow:31, ccol:0,  con:0, pct:100, exp_row:0,  faddr:'h415, inv_col:-1, inv_val:8'h00};
        tbl[1] = '{y:16,  top:31, crow:0,  ccol:0,  con:0, pct:100, exp_row:0,  faddr:'h410, inv_col:-1, inv_val:8'h00};
        tbl[2] = '{y:480, top:0,  crow:0,  ccol:0,  con:1, pct:100, exp_row:-1, faddr:-1,    inv_col:-1, inv_val:8'h00};
        tbl[3] = '{y:48,  top:0,  crow:3,  ccol:99, con:1, pct:100, exp_row:3,  faddr:-1,    inv_col:99, inv_val:8'hE7};
        tbl[4] = '{y:48,  top:0,  crow:3,  ccol:99, con:0, pct:100, exp_row:3,  faddr:-1,    inv_col:99, inv_val:8'h18};
        tbl[5] = '{y:100, top:28, crow:2,  ccol:0,  con:1, pct:30,  exp_row:2,  faddr:-1,    inv_col:0,  inv_val:8'h5A};
        tbl[6] = '{y:479, top:5,  crow:0,  ccol:0,  con:0, pct:30,  exp_row:2,  faddr:-1,    inv_col:-1, inv_val:8'h00};
        tbl[7] = '{y:511, top:3,  crow:2,  ccol:5,  con:1, pct:70,  exp_row:-1, faddr:-1,    inv_col:5,  inv_val:8'h00};
        tbl[8] = '{y:0,   top:0,  crow:0,  ccol:7,  con:0, pct:30,  exp_row:0,  faddr:'h410, inv_col:-1, inv_val:8'h00};

        #2 reset_low = 1'b0;
        #1;
        chk("reset_line_ready", int'(line_ready), 1);
        chk("reset_ram_rd_en", int'(ram_rd_en), 0);
        chk("reset_font_rd_en", int'(font_rd_en), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_last", int'(out_last), 0);
        chk("reset_out_bits", int'(out_bits), 0);
        chk("reset_addrs", int'({ram_row, ram_col, font_addr}), 0);
        @(posedge clk); #1 reset_low = 1'b1;

        // Reset in the middle of a line, then a clean full line.
        v = '{y:0, top:0, crow:0, ccol:0, con:0, pct:100, exp_row:0, faddr:-1, inv_col:-1, inv_val:8'h00};
        start_line(v, 1'b0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk); #1;
                if (ram_rd_en && ram_col == 7'd50) begin seen = 1'b1; break; end
            end
            chk("reach_col50", int'(seen), 1);
        end
        reset_low = 1'b0;
        expq.delete();
        byte_idx = 0;
        total_issued = nb_popped;
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_line_ready", int'(line_ready), 1);
        @(posedge clk); #1 reset_low = 1'b1;
        run_vec(v);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Back-to-back lines with line_valid held high.
        v = '{y:0, top:0, crow:0, ccol:0, con:0, pct:100, exp_row:0, faddr:-1, inv_col:-1, inv_val:8'h00};
        start_line(v, 1'b1);
        accs[0] = acc;
        for (int k = 1; k < 3; k++) begin
            line_y = 9'(k);
            begin
                bit ok = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk); #1;
                    if (line_ready) begin ok = 1'b1; break; end
                end
                chk("b2b_accept", int'(ok), 1);
            end
            accs[k] = ncyc;
            push_line(k, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        line_valid = 1'b0;
        wait_drain("b2b_done");
        chk("b2b_gap1", accs[1] - accs[0], 103);
        chk("b2b_gap2", accs[2] - accs[1], 103);
        chk("b2b_lasts", lasts, 3);
        chk("b2b_rd_count", rd_cnt, 300);
        chk("b2b_rd_addr_bad", rd_bad, 0);
        chk("b2b_credit_bad", credit_bad, 0);

        // Randomized lines under mixed backpressure.
        for (int k = 0; k < 15; k++) begin
            int sr, pr;
            v.y = int'($urandom_range(511));
            v.top = int'($urandom_range(31));
            sr = v.y / 16;
            pr = (v.top + sr) % 32;
            v.crow = ($urandom_range(1) == 1) ? pr : int'($urandom_range(31));
            v.ccol = int'($urandom_range(99));
            v.con = int'($urandom_range(1));
            case ($urandom_range(2))
                0:       v.pct = 30;
                1:       v.pct = 70;
                default: v.pct = 100;
            endcase
            v.exp_row = (sr >= 30) ? -1 : pr;
            v.faddr = -1;
            v.inv_col = -1;
            v.inv_val = 8'h00;
            run_vec(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
